multicycle_control: RTL

//   Main control FSM for the multicycle MIPS32 core; drives the ALU-op class (o_aluOp) consumed by aluControl plus
//   all datapath enables/muxes. Sequences FETCH/DECODE/EXECUTE/MEM/WB per opcode, stalling on memory handshake.

---
 rtl/multicycle_control_pkg.sv | 59 +++++
 rtl/multicycle_control_out_decode.sv | 75 +++++++
 rtl/multicycle_control.sv | 112 +++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS32 main control FSM.
//   - opcode values for the supported instruction classes
//   - ALU-op class codes consumed by aluControl
//   - state encoding (also exported on the o_state debug port)
//   - ctrl_t: the full datapath control word decoded from a state
package multicycle_control_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned SEL_W    = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALU_OP_W-1:0] ALU_OP_ADD  = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SUB  = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALU_OP_FUNC = 2'b10;
    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP  = 2'b11;   // reserved, never driven

    typedef enum logic [STATE_W-1:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    typedef struct packed {
        logic                pc_write;
        logic                pc_write_cond;
        logic                ior_d;
        logic                mem_read;
        logic                mem_write;
        logic                ir_write;
        logic                mem_to_reg;
        logic                reg_dst;
        logic                reg_write;
        logic                alu_src_a;
        logic [SEL_W-1:0]    alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic [SEL_W-1:0]    pc_src;
        logic                illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_out_decode.sv
// Pure combinational state -> control word decoder.
//   state : FSM state to decode
//   ctrl  : datapath control word for that state (all zero for S_RESET
//           and for any unused encoding)
module multicycle_control_out_decode
    import multicycle_control_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALU_OP_ADD;
                ctrl.pc_src    = 2'b00;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALU_OP_FUNC;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = 2'b00;
                ctrl.alu_op        = ALU_OP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = 2'b01;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 2'b10;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS32 core.
//   i_clk, i_rst_n   : clock (rising edge), async active-low reset
//   i_op             : IR opcode field, valid from DECODE onward
//   i_memReady       : memory completes the current access this cycle
//   o_*              : datapath enables / mux selects, ALU-op class,
//                      1-cycle illegal-opcode pulse, o_state debug
// The control word is registered from the decode of the next state, so
// outputs always correspond to the current state and clear together with
// it on reset. PC/IR writes in FETCH are additionally qualified by
// i_memReady so the fetch commits exactly once, on the completing cycle.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OPCODE_W-1:0] i_op,
    input  logic                i_memReady,
    output logic                o_pcWrite,
    output logic                o_pcWriteCond,
    output logic                o_iorD,
    output logic                o_memRead,
    output logic                o_memWrite,
    output logic                o_irWrite,
    output logic                o_memToReg,
    output logic                o_regDst,
    output logic                o_regWrite,
    output logic                o_aluSrcA,
    output logic [SEL_W-1:0]    o_aluSrcB,
    output logic [ALU_OP_W-1:0] o_aluOp,
    output logic [SEL_W-1:0]    o_pcSrc,
    output logic                o_illegal,
    output logic [STATE_W-1:0]  o_state
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_nxt;
    ctrl_t  ctrl_q;
    logic   fetch_wait;

    multicycle_control_out_decode u_out_decode (
        .state (state_nxt),
        .ctrl  (ctrl_nxt)
    );

    // State and control-word registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= S_RESET;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = S_RESET;
        case (state)
            S_RESET:  state_nxt = S_FETCH;
            S_FETCH:  state_nxt = i_memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (i_op)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_ILLEGAL;
                endcase
            end
            // IR is stable, so i_op still holds the decoded lw/sw opcode
            S_MEMADR: begin
                if (i_op == OP_SW)      state_nxt = S_MEMWR;
                else if (i_op == OP_LW) state_nxt = S_MEMRD;
                else                    state_nxt = S_ILLEGAL;
            end
            S_MEMRD:   state_nxt = i_memReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_nxt = S_FETCH;
            S_MEMWR:   state_nxt = i_memReady ? S_FETCH : S_MEMWR;
            S_EXEC:    state_nxt = S_ALUWB;
            S_ALUWB:   state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_ADDIEX:  state_nxt = S_ADDIWB;
            S_ADDIWB:  state_nxt = S_FETCH;
            S_JUMP:    state_nxt = S_FETCH;
            S_ILLEGAL: state_nxt = S_FETCH;
            default:   state_nxt = S_RESET;
        endcase
    end

    // Hold off PC/IR commit while the instruction fetch is still pending
    assign fetch_wait = (state == S_FETCH) && !i_memReady;

    assign o_pcWrite     = ctrl_q.pc_write & ~fetch_wait;
    assign o_irWrite     = ctrl_q.ir_write & ~fetch_wait;
    assign o_pcWriteCond = ctrl_q.pc_write_cond;
    assign o_iorD        = ctrl_q.ior_d;
    assign o_memRead     = ctrl_q.mem_read;
    assign o_memWrite    = ctrl_q.mem_write;
    assign o_memToReg    = ctrl_q.mem_to_reg;
    assign o_regDst      = ctrl_q.reg_dst;
    assign o_regWrite    = ctrl_q.reg_write;
    assign o_aluSrcA     = ctrl_q.alu_src_a;
    assign o_aluSrcB     = ctrl_q.alu_src_b;
    assign o_aluOp       = ctrl_q.alu_op;
    assign o_pcSrc       = ctrl_q.pc_src;
    assign o_illegal     = ctrl_q.illegal;
    assign o_state       = STATE_W'(state);

endmodule
